// File: rtl/usb_hid_pkg.sv
// ---------------------------------------------------------------------------
// usb_hid_pkg : shared encodings for the HID report decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usb_hid_pkg;

  localparam logic [1:0] TYP_NONE    = 2'd0;
  localparam logic [1:0] TYP_KBD     = 2'd1;
  localparam logic [1:0] TYP_MOUSE   = 2'd2;
  localparam logic [1:0] TYP_GAMEPAD = 2'd3;

  localparam logic [7:0] HID_CLASS     = 8'h03;
  localparam logic [7:0] BOOT_SUBCLASS = 8'h01;
  localparam logic [7:0] PROTO_KBD     = 8'h01;
  localparam logic [7:0] KEY_ROLLOVER  = 8'h01;
  localparam logic [1:0] DS2_FILLER    = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Returns {positive, negative} for one gamepad axis byte.
  function automatic logic [1:0] axis_dir(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    return {v > hi, v < lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_hid_sat_acc.sv
// ---------------------------------------------------------------------------
// usb_hid_sat_acc : signed saturating accumulator for one mouse axis
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_hid_sat_acc #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [7:0]       delta,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_q, acc_d, base_w;
  logic [ACC_W:0]   sum_w;

  always_comb begin
    // A clear in the same cycle as an add keeps only the new delta.
    base_w = clr ? '0 : acc_q;
    sum_w  = {base_w[ACC_W-1], base_w} + {{(ACC_W-7){delta[7]}}, delta};
    acc_d  = base_w;
    if (add_en) begin
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/usb_hid_report_decoder.sv
// ---------------------------------------------------------------------------
// usb_hid_report_decoder : buffers a ukp frame and decodes it in one commit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_hid_report_decoder
  import usb_hid_pkg::*;
#(
  parameter int         MAX_BYTES = 8,
  parameter int         NKEYS     = 6,
  parameter int         ACC_W     = 12,
  parameter logic [7:0] AXIS_LO   = 8'h40,
  parameter logic [7:0] AXIS_HI   = 8'hBF
) (
  input  logic                   usbclk,
  input  logic                   usbrst,
  input  logic                   ukp_rdy,
  input  logic                   ukp_stb,
  input  logic [7:0]             ukp_dat,
  input  logic                   save,
  input  logic [3:0]             save_r,
  input  logic [3:0]             save_b,
  input  logic                   connected,
  output logic [1:0]             typ,
  output logic                   report,
  output logic                   short_err,
  output logic                   overrun,
  output logic [4:0]             rpt_len,
  output logic [7:0]             key_modifiers,
  output logic [8*NKEYS-1:0]     keys,
  output logic [7:0]             mouse_btn,
  output logic [ACC_W-1:0]       mouse_dx,
  output logic [ACC_W-1:0]       mouse_dy,
  output logic [7:0]             mouse_wheel,
  input  logic                   mouse_ack,
  output logic [9:0]             game_btn,
  output logic [8*MAX_BYTES-1:0] dbg_hid_report
);

  state_e state_q, state_d;
  logic [4:0] rcvct_q, rcvct_d;
  logic [MAX_BYTES-1:0][7:0] buf_q, buf_d;
  logic [2:0][7:0] regs_q, regs_d;
  logic rdy_q, rdy_d, stb_q, stb_d, stb2_q, stb2_d, conn_q, conn_d, save_q, save_d;
  logic [7:0] dat_q, dat_d;
  logic [1:0] typ_q, typ_d;
  logic report_q, report_d, short_err_q, short_err_d, overrun_q, overrun_d;
  logic [4:0] rpt_len_q, rpt_len_d;
  logic [7:0] key_mod_q, key_mod_d, mouse_btn_q, mouse_btn_d, wheel_q, wheel_d;
  logic [8*NKEYS-1:0] keys_q, keys_d, keys_w;
  logic [NKEYS-1:0] roll_w;
  logic [9:0] game_btn_q, game_btn_d;
  logic [15:0][7:0] byte_w;
  logic [1:0] lr_w, ud_w;
  logic stb_edge, disc, save_fall, buf_we, acc_add, acc_clr;

  assign stb_edge  = stb_q & ~stb2_q;
  assign disc      = conn_q & ~connected;
  assign save_fall = save_q & ~save;
  assign acc_clr   = mouse_ack | disc;

  // Zero-padded 16-byte view so any 4-bit index is safe.
  for (genvar i = 0; i < 16; i++) begin : g_pad
    if (i < MAX_BYTES) begin : g_in
      assign byte_w[i] = buf_q[i];
    end else begin : g_zero
      assign byte_w[i] = 8'h00;
    end
  end

  for (genvar i = 0; i < MAX_BYTES; i++) begin : g_buf
    assign buf_d[i] = (buf_we && rcvct_q == 5'(i)) ? dat_q : buf_q[i];
  end

  // Only the class/subclass/protocol slots (4..6) influence behaviour.
  for (genvar i = 0; i < 3; i++) begin : g_regs
    assign regs_d[i] = (save && save_r == 4'(i + 4)) ? byte_w[save_b] : regs_q[i];
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_keys
    assign keys_w[8*i +: 8] = byte_w[2+i];
    assign roll_w[i]        = (byte_w[2+i] == KEY_ROLLOVER);
  end

  assign lr_w = axis_dir(byte_w[3], AXIS_LO, AXIS_HI);
  assign ud_w = axis_dir(byte_w[4], AXIS_LO, AXIS_HI);

  always_comb begin
    state_d     = state_q;
    rcvct_d     = rcvct_q;
    rdy_d       = ukp_rdy;
    stb_d       = ukp_stb;
    stb2_d      = stb_q;
    dat_d       = ukp_dat;
    conn_d      = connected;
    save_d      = save;
    buf_we      = 1'b0;
    acc_add     = 1'b0;
    typ_d       = typ_q;
    report_d    = 1'b0;
    short_err_d = 1'b0;
    overrun_d   = overrun_q;
    rpt_len_d   = rpt_len_q;
    key_mod_d   = key_mod_q;
    keys_d      = keys_q;
    mouse_btn_d = mouse_btn_q;
    wheel_d     = wheel_q;
    game_btn_d  = game_btn_q;

    case (state_q)
      IDLE: begin
        if (rdy_q) begin
          state_d = CAPTURE;
          rcvct_d = '0;
        end
      end
      CAPTURE: begin
        // Frame end wins over a coincident strobe edge.
        if (!rdy_q) begin
          state_d = COMMIT;
        end else if (stb_edge) begin
          if (rcvct_q < 5'(MAX_BYTES)) buf_we = 1'b1;
          else                         overrun_d = 1'b1;
          if (rcvct_q != 5'd16) rcvct_d = rcvct_q + 5'd1;
        end
      end
      COMMIT: begin
        state_d   = IDLE;
        rpt_len_d = rcvct_q;
        case (typ_q)
          TYP_KBD: begin
            if (rcvct_q < 5'(2 + NKEYS)) begin
              short_err_d = 1'b1;
            end else begin
              report_d  = 1'b1;
              key_mod_d = byte_w[0];
              if (!(&roll_w)) keys_d = keys_w;
            end
          end
          TYP_MOUSE: begin
            if (rcvct_q < 5'd3) begin
              short_err_d = 1'b1;
            end else begin
              report_d    = 1'b1;
              mouse_btn_d = byte_w[0];
              acc_add     = 1'b1;
              wheel_d     = (rcvct_q >= 5'd4) ? byte_w[3] : 8'h00;
            end
          end
          TYP_GAMEPAD: begin
            if (rcvct_q < 5'd7) begin
              short_err_d = 1'b1;
            end else if (byte_w[0][1:0] != DS2_FILLER) begin
              report_d   = 1'b1;
              game_btn_d = {byte_w[6][5], byte_w[6][4], byte_w[5][7], byte_w[5][4],
                            byte_w[5][6], byte_w[5][5], ud_w[1], ud_w[0], lr_w[1], lr_w[0]};
            end
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    if (save_fall && save_r == 4'd6) begin
      if (regs_q[0] != HID_CLASS)          typ_d = TYP_NONE;
      else if (regs_q[1] != BOOT_SUBCLASS) typ_d = TYP_GAMEPAD;
      else if (regs_q[2] == PROTO_KBD)     typ_d = TYP_KBD;
      else                                 typ_d = TYP_MOUSE;
    end

    // Disconnect aborts any frame in flight and wipes decoded state.
    if (disc) begin
      state_d     = IDLE;
      buf_we      = 1'b0;
      acc_add     = 1'b0;
      typ_d       = TYP_NONE;
      report_d    = 1'b0;
      short_err_d = 1'b0;
      overrun_d   = 1'b0;
      rpt_len_d   = '0;
      key_mod_d   = '0;
      keys_d      = '0;
      mouse_btn_d = '0;
      wheel_d     = '0;
      game_btn_d  = '0;
    end
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      state_q     <= IDLE;
      rcvct_q     <= '0;
      buf_q       <= '0;
      regs_q      <= '0;
      rdy_q       <= 1'b0;
      stb_q       <= 1'b0;
      stb2_q      <= 1'b0;
      dat_q       <= '0;
      conn_q      <= 1'b0;
      save_q      <= 1'b0;
      typ_q       <= TYP_NONE;
      report_q    <= 1'b0;
      short_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rpt_len_q   <= '0;
      key_mod_q   <= '0;
      keys_q      <= '0;
      mouse_btn_q <= '0;
      wheel_q     <= '0;
      game_btn_q  <= '0;
    end else begin
      state_q     <= state_d;
      rcvct_q     <= rcvct_d;
      buf_q       <= buf_d;
      regs_q      <= regs_d;
      rdy_q       <= rdy_d;
      stb_q       <= stb_d;
      stb2_q      <= stb2_d;
      dat_q       <= dat_d;
      conn_q      <= conn_d;
      save_q      <= save_d;
      typ_q       <= typ_d;
      report_q    <= report_d;
      short_err_q <= short_err_d;
      overrun_q   <= overrun_d;
      rpt_len_q   <= rpt_len_d;
      key_mod_q   <= key_mod_d;
      keys_q      <= keys_d;
      mouse_btn_q <= mouse_btn_d;
      wheel_q     <= wheel_d;
      game_btn_q  <= game_btn_d;
    end
  end

  usb_hid_sat_acc #(.ACC_W(ACC_W)) u_acc_dx (
    .clk   (usbclk),
    .rst   (usbrst),
    .clr   (acc_clr),
    .add_en(acc_add),
    .delta (byte_w[1]),
    .acc   (mouse_dx)
  );

  usb_hid_sat_acc #(.ACC_W(ACC_W)) u_acc_dy (
    .clk   (usbclk),
    .rst   (usbrst),
    .clr   (acc_clr),
    .add_en(acc_add),
    .delta (byte_w[2]),
    .acc   (mouse_dy)
  );

  assign typ            = typ_q;
  assign report         = report_q;
  assign short_err      = short_err_q;
  assign overrun        = overrun_q;
  assign rpt_len        = rpt_len_q;
  assign key_modifiers  = key_mod_q;
  assign keys           = keys_q;
  assign mouse_btn      = mouse_btn_q;
  assign mouse_wheel    = wheel_q;
  assign game_btn       = game_btn_q;
  assign dbg_hid_report = buf_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_hid_report_decoder.sv
// ---------------------------------------------------------------------------
// tb_usb_hid_report_decoder : directed self-checking bench for the decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usb_hid_report_decoder;

  logic        usbclk = 1'b0;
  logic        usbrst;
  logic        ukp_rdy, ukp_stb, save, connected, mouse_ack;
  logic [7:0]  ukp_dat;
  logic [3:0]  save_r, save_b;
  logic [1:0]  typ;
  logic        report, short_err, overrun;
  logic [4:0]  rpt_len;
  logic [7:0]  key_modifiers, mouse_btn, mouse_wheel;
  logic [47:0] keys;
  logic [7:0]  mouse_dx, mouse_dy;
  logic [9:0]  game_btn;
  logic [63:0] dbg_hid_report;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] fb[$];
  logic pre_rep, rep, serr, rep_seen;

  always #42 usbclk = ~usbclk;

  usb_hid_report_decoder #(
    .MAX_BYTES(8), .NKEYS(6), .ACC_W(8), .AXIS_LO(8'h40), .AXIS_HI(8'hBF)
  ) dut (
    .usbclk        (usbclk),
    .usbrst        (usbrst),
    .ukp_rdy       (ukp_rdy),
    .ukp_stb       (ukp_stb),
    .ukp_dat       (ukp_dat),
    .save          (save),
    .save_r        (save_r),
    .save_b        (save_b),
    .connected     (connected),
    .typ           (typ),
    .report        (report),
    .short_err     (short_err),
    .overrun       (overrun),
    .rpt_len       (rpt_len),
    .key_modifiers (key_modifiers),
    .keys          (keys),
    .mouse_btn     (mouse_btn),
    .mouse_dx      (mouse_dx),
    .mouse_dy      (mouse_dy),
    .mouse_wheel   (mouse_wheel),
    .mouse_ack     (mouse_ack),
    .game_btn      (game_btn),
    .dbg_hid_report(dbg_hid_report)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge usbclk);
    #1;
  endtask

  // Sends fb as one frame; report expected two edges after ukp_rdy is sampled low.
  task automatic run_frame(input bit ack);
    ukp_rdy = 1'b1;
    tick; tick;
    foreach (fb[i]) begin
      ukp_dat = fb[i];
      ukp_stb = 1'b1;
      tick;
      ukp_stb = 1'b0;
      tick;
    end
    ukp_rdy = 1'b0;
    tick; tick;
    pre_rep = report;
    if (ack) mouse_ack = 1'b1;
    tick;
    mouse_ack = 1'b0;
    rep  = report;
    serr = short_err;
  endtask

  task automatic save_reg(input logic [3:0] r, input logic [3:0] b);
    save_r = r;
    save_b = b;
    save   = 1'b1;
    tick;
    save   = 1'b0;
    tick;
  endtask

  task automatic set_typ(input logic [7:0] c, input logic [7:0] s, input logic [7:0] p);
    fb = '{c, s, p};
    run_frame(1'b0);
    save_reg(4'd4, 4'd0);
    save_reg(4'd5, 4'd1);
    save_reg(4'd6, 4'd2);
  endtask

  initial begin
    usbrst = 1'b1; ukp_rdy = 1'b0; ukp_stb = 1'b0; ukp_dat = 8'h00;
    save = 1'b0; save_r = 4'd0; save_b = 4'd0; connected = 1'b1; mouse_ack = 1'b0;
    tick; tick;
    check("rst_typ", 64'(typ), 64'h0);
    check("rst_keys", keys, 64'h0);
    check("rst_rpt_len", 64'(rpt_len), 64'h0);
    check("rst_dbg", dbg_hid_report, 64'h0);
    usbrst = 1'b0;
    tick;

    // Keyboard
    set_typ(8'h03, 8'h01, 8'h01);
    check("kbd_typ", 64'(typ), 64'h1);
    fb = '{8'h02, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    check("kbd_rep_early", 64'(pre_rep), 64'h0);
    check("kbd_rep", 64'(rep), 64'h1);
    check("kbd_mod", 64'(key_modifiers), 64'h02);
    check("kbd_keys", keys, 64'h0000_0000_0504);
    check("kbd_len", 64'(rpt_len), 64'h8);

    fb = '{8'h07, 8'h00, 8'h09, 8'h0A, 8'h0B};
    run_frame(1'b0);
    check("kbd_short_err", 64'(serr), 64'h1);
    check("kbd_short_rep", 64'(rep), 64'h0);
    check("kbd_short_mod", 64'(key_modifiers), 64'h02);
    check("kbd_short_keys", keys, 64'h0000_0000_0504);

    fb = '{8'h04, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_frame(1'b0);
    check("roll_rep", 64'(rep), 64'h1);
    check("roll_mod", 64'(key_modifiers), 64'h04);
    check("roll_keys", keys, 64'h0000_0000_0504);

    fb.delete();
    for (int i = 0; i < 20; i++) fb.push_back(8'(8'h10 + i));
    run_frame(1'b0);
    check("ovr_flag", 64'(overrun), 64'h1);
    check("ovr_len", 64'(rpt_len), 64'd16);
    check("ovr_mod", 64'(key_modifiers), 64'h10);
    check("ovr_keys", keys, 64'h1716_1514_1312);
    check("ovr_dbg", dbg_hid_report, 64'h1716_1514_1312_1110);

    // Mouse
    set_typ(8'h03, 8'h01, 8'h02);
    check("mouse_typ", 64'(typ), 64'h2);
    fb = '{8'h00, 8'h7F, 8'h00};
    run_frame(1'b0);
    check("dx_first", 64'(mouse_dx), 64'h7F);
    run_frame(1'b0);
    run_frame(1'b0);
    check("dx_sat_pos", 64'(mouse_dx), 64'h7F);
    mouse_ack = 1'b1; tick; mouse_ack = 1'b0;
    check("dx_ack_clear", 64'(mouse_dx), 64'h00);
    fb = '{8'h00, 8'h80, 8'h00};
    run_frame(1'b0);
    check("dx_neg", 64'(mouse_dx), 64'h80);
    run_frame(1'b0);
    check("dx_sat_neg", 64'(mouse_dx), 64'h80);
    mouse_ack = 1'b1; tick; mouse_ack = 1'b0;
    run_frame(1'b0);
    check("dx_neg_after_ack", 64'(mouse_dx), 64'h80);
    fb = '{8'h01, 8'h05, 8'hFD, 8'h02};
    run_frame(1'b1);
    check("ack_commit_dx", 64'(mouse_dx), 64'h05);
    check("ack_commit_dy", 64'(mouse_dy), 64'hFD);
    check("mouse_wheel", 64'(mouse_wheel), 64'h02);
    check("mouse_btn", 64'(mouse_btn), 64'h01);
    fb = '{8'h00, 8'h01, 8'h01};
    run_frame(1'b0);
    check("acc_dx", 64'(mouse_dx), 64'h06);
    check("acc_dy", 64'(mouse_dy), 64'hFE);
    check("wheel_short", 64'(mouse_wheel), 64'h00);

    // Gamepad
    set_typ(8'h03, 8'h00, 8'h00);
    check("pad_typ", 64'(typ), 64'h3);
    fb = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h20, 8'h10};
    run_frame(1'b0);
    check("ds2_rep", 64'(rep), 64'h0);
    check("ds2_serr", 64'(serr), 64'h0);
    check("ds2_btn", 64'(game_btn), 64'h000);
    fb = '{8'h01, 8'h7F, 8'h7F, 8'h00, 8'hFF, 8'h20, 8'h10};
    run_frame(1'b0);
    check("pad_rep", 64'(rep), 64'h1);
    check("pad_btn", 64'(game_btn), 64'h119);
    fb = '{8'h01, 8'h80, 8'h80, 8'h80, 8'h40, 8'h80, 8'h20};
    run_frame(1'b0);
    check("pad_btn_thresh", 64'(game_btn), 64'h280);
    check("ovr_sticky", 64'(overrun), 64'h1);

    // Disconnect in the middle of a capture
    ukp_rdy = 1'b1;
    tick; tick;
    ukp_dat = 8'h01; ukp_stb = 1'b1; tick; ukp_stb = 1'b0; tick;
    connected = 1'b0;
    tick;
    check("disc_typ", 64'(typ), 64'h0);
    check("disc_btn", 64'(game_btn), 64'h000);
    check("disc_dx", 64'(mouse_dx), 64'h00);
    check("disc_dy", 64'(mouse_dy), 64'h00);
    check("disc_ovr", 64'(overrun), 64'h0);
    check("disc_len", 64'(rpt_len), 64'h0);
    check("disc_keys", keys, 64'h0);
    rep_seen = report;
    ukp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      rep_seen = rep_seen | report;
    end
    check("disc_no_report", 64'(rep_seen), 64'h0);
    connected = 1'b1;
    tick;

    // Asynchronous reset mid-frame
    set_typ(8'h03, 8'h00, 8'h00);
    fb = '{8'h01, 8'h7F, 8'h7F, 8'h00, 8'hFF, 8'h20, 8'h10};
    run_frame(1'b0);
    check("pre_rst_btn", 64'(game_btn), 64'h119);
    ukp_rdy = 1'b1;
    tick; tick;
    ukp_dat = 8'h55; ukp_stb = 1'b1; tick;
    #10;
    usbrst = 1'b1;
    #1;
    check("arst_typ", 64'(typ), 64'h0);
    check("arst_btn", 64'(game_btn), 64'h000);
    check("arst_len", 64'(rpt_len), 64'h0);
    check("arst_dbg", dbg_hid_report, 64'h0);
    ukp_stb = 1'b0; ukp_rdy = 1'b0;
    tick;
    usbrst = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_hid_report_decoder.md
Name: usb_hid_report_decoder

Overview:
Parametrised successor of the HID report path that sits between the ukp microcode engine and user logic.
- Buffers each ukp data frame completely, then decodes it atomically in one commit cycle.
- Classifies the device from saved interface descriptor bytes.
- Outputs: keyboard state with configurable key slots, saturating mouse accumulators (with wheel) under a consumer ack handshake, and threshold-configurable gamepad directions.

Parameters:
- MAX_BYTES, 8, report buffer depth in bytes (4..16); bytes beyond this are dropped.
- NKEYS, 6, keyboard key slots decoded from bytes 2..(1+NKEYS) (1..6).
- ACC_W, 12, signed mouse accumulator width (8..16).
- AXIS_LO, 8'h40, gamepad axis value below this means negative direction.
- AXIS_HI, 8'hBF, gamepad axis value above this means positive direction.

Ports:
- usbclk  in  1  12 MHz clock
- usbrst  in  1  asynchronous active-high reset
- ukp_rdy  in  1  frame active from ukp
- ukp_stb  in  1  byte strobe; its rising edge qualifies ukp_dat
- ukp_dat  in  8  frame byte
- save  in  1  pulse: regs[save_r] <= buf[save_b]
- save_r  in  4  descriptor register index (0..6)
- save_b  in  4  buffer byte index
- connected  in  1  device connected level
- typ  out  2  0 none, 1 keyboard, 2 mouse, 3 gamepad
- report  out  1  one-cycle pulse per accepted report
- short_err  out  1  one-cycle pulse, report too short for typ
- overrun  out  1  sticky; set when a frame exceeds MAX_BYTES; cleared on disconnect
- rpt_len  out  5  byte count of the last frame
- key_modifiers  out  8
- keys  out  8*NKEYS  slot i at [8i+7:8i]
- mouse_btn  out  8
- mouse_dx, mouse_dy  out  ACC_W  signed accumulated motion
- mouse_wheel  out  8  signed, last report
- mouse_ack  in  1  consumer has read the accumulators; clears them
- game_btn  out  10  {sta,sel,y,x,b,a,d,u,r,l}
- dbg_hid_report  out  8*MAX_BYTES  raw buffer, byte 0 in LSBs

Behaviour:
- Reset (async): every output 0, FSM in IDLE, rcvct 0, descriptor regs 0.
- FSM states:
  - IDLE: ukp_rdy=1 → CAPTURE with rcvct=0.
  - CAPTURE: each ukp_stb rising edge (registered compare) stores buf[rcvct] when rcvct<MAX_BYTES, otherwise sets overrun; rcvct saturates at 16. ukp_rdy=0 → COMMIT.
  - COMMIT: one cycle → IDLE.
- A strobe edge coincident with the ukp_rdy fall is ignored.
- Latency: ukp_rdy sampled low at edge N; COMMIT during cycle N+1; outputs and report valid from edge N+2.
- COMMIT decode, by typ:
  - typ=0: nothing decoded; rpt_len still updated.
  - Keyboard:
    - Requires rpt_len ≥ 2+NKEYS, else short_err and no output change.
    - key_modifiers=buf[0].
    - keys updated, unless every key byte is 8'h01 (ErrorRollOver), in which case keys are held and modifiers still update.
  - Mouse:
    - Requires rpt_len ≥ 3.
    - mouse_btn=buf[0].
    - dx/dy are sign-extended and added to the accumulators, saturating at +2^(ACC_W-1)-1 / -2^(ACC_W-1).
    - mouse_wheel=buf[3] if rpt_len ≥ 4, else 0.
  - Gamepad:
    - Requires rpt_len ≥ 7.
    - If buf[0][1:0]==2'b10 (DS2 adapter filler), the frame is discarded: no report, no short_err.
    - l/r from buf[3] and u/d from buf[4] against AXIS_LO/AXIS_HI; a value in range gives 0 for both directions.
    - x,a,b,y = buf[5][4..7]; sel,sta = buf[6][4..5].
- report pulses at the commit of every accepted frame; short_err and report are never both high.
- mouse_ack:
  - Alone: clears dx/dy on the next edge.
  - In the COMMIT cycle: old values are discarded and the result equals the new deltas only.
- Typing:
  - On save, regs[save_r] <= buf[save_b] (index ≥ MAX_BYTES reads 0).
  - On the save falling edge with save_r==6:
    - class(reg4)==3 and subclass(reg5)==1: typ = reg6==1 ? 1 : 2.
    - class 3, other subclass: typ=3.
    - Any other class: typ=0.
- Disconnect (connected falling edge, registered):
  - typ, all decoded outputs, overrun and rpt_len cleared next edge.
  - An in-flight CAPTURE is aborted to IDLE, and its COMMIT is suppressed.

Decomposition:
- Package usb_hid_pkg holds:
  - typ encodings (TYP_NONE/KBD/MOUSE/GAMEPAD)
  - HID_CLASS=3, BOOT_SUBCLASS=1, PROTO_KBD=1
  - KEY_ROLLOVER=8'h01
  - DS2_FILLER=2'b10
  - FSM state enum {IDLE,CAPTURE,COMMIT}
- Sub-module usb_hid_sat_acc (ACC_W parametrised): signed add, clear input, saturation. Instantiated for dx and dy.

Test Plan:
- Keyboard typ; 8-byte frame 02 00 04 05 00 00 00 00 → report at fall+2; key_modifiers=02; keys slot0=04, slot1=05, rest 0; rpt_len=8.
- Mouse, ACC_W=8, no ack; three frames with dx=7F → mouse_dx saturates to 7F; then dx=80 ×2 with ack between → -128, not wrapped. mouse_ack in the COMMIT cycle with dx=05 → mouse_dx=5.
- Gamepad; buf0=02 → no report. Then 01 7F 7F 00 FF 20 10 → game_btn l=1, d=1, a=1, sel=1.
- Keyboard typ with a 5-byte frame → short_err pulse, outputs unchanged. 20-byte frame → overrun=1, rpt_len=16, bytes 0..7 decoded.
- Descriptor saves (4←03, 5←01, 6←02) → typ=2. Drop connected mid-CAPTURE → typ=0, no report, outputs 0. Assert usbrst mid-frame → all outputs 0 immediately.
